vx_dispatch_launcher: RTL

- Consumer of the arbitrated dispatch bus.
- Accepts one block request {req_id, req_size_m1, req_core_id} and launches that block onto req_size_m1+1 consecutive cores, starting at req_core_id and wrapping modulo NUM_CORES.
- Tracks per-core completion and returns rsp_valid/rsp_id once every core of a block has finished.
- Sits at cluster level, between the dispatch arbiter's bus_out_if and the cores' launch/done ports.

---
 rtl/vx_dispatch_pkg.sv | 23 ++
 rtl/vx_dispatch_slot_table.sv | 90 +++++++++
 rtl/vx_dispatch_launcher.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vx_dispatch_pkg.sv
// Shared types for the dispatch launcher: slot table entry, launch FSM states and geometry.
// slot_t and SLOT_W are sized from the default geometry below.
package vx_dispatch_pkg;

  localparam int VX_NUM_CORES   = 4;
  localparam int VX_NC_WIDTH    = $clog2(VX_NUM_CORES);
  localparam int VX_NB_WIDTH    = 4;
  localparam int VX_MAX_PENDING = 4;
  localparam int SLOT_W         = $clog2(VX_MAX_PENDING);

  typedef struct packed {
    logic                   valid;
    logic [VX_NB_WIDTH-1:0] id;
    logic [VX_NC_WIDTH:0]   remaining;
    logic                   rsp_pend;
  } slot_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LAUNCH = 1'b1
  } launch_state_e;

endpackage

// File: rtl/vx_dispatch_slot_table.sv
// Pending-block table: lowest-free allocation, per-slot completion counting from core dones,
// and a registered one-per-cycle completion response with lowest-slot priority.
module vx_dispatch_slot_table
  import vx_dispatch_pkg::*;
#(
  parameter int NUM_CORES   = VX_NUM_CORES,
  parameter int NC_WIDTH    = $clog2(NUM_CORES),
  parameter int NB_WIDTH    = VX_NB_WIDTH,
  parameter int MAX_PENDING = VX_MAX_PENDING
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_en,
  input  logic [NB_WIDTH-1:0]           alloc_id,
  input  logic [NC_WIDTH:0]             alloc_cnt,
  output logic                          free_avail,
  output logic [SLOT_W-1:0]             free_idx,
  input  logic [NUM_CORES-1:0]          done_mask,
  input  logic [NUM_CORES*SLOT_W-1:0]   owner_flat,
  output logic                          rsp_valid,
  output logic [NB_WIDTH-1:0]           rsp_id
);

  slot_t                slots    [MAX_PENDING];
  logic [NC_WIDTH:0]    dec_cnt  [MAX_PENDING];
  logic [NC_WIDTH:0]    rem_next [MAX_PENDING];
  logic [MAX_PENDING-1:0] done_now;
  logic                 win_valid;
  logic [SLOT_W-1:0]    win_idx;

  always_comb begin
    for (int s = 0; s < MAX_PENDING; s++) begin
      dec_cnt[s] = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (done_mask[c] && (owner_flat[c*SLOT_W +: SLOT_W] == SLOT_W'(s)))
          dec_cnt[s] = dec_cnt[s] + (NC_WIDTH+1)'(1);
      end
      rem_next[s] = slots[s].remaining - dec_cnt[s];
      done_now[s] = slots[s].valid && (dec_cnt[s] != '0) && (rem_next[s] == '0);
    end
  end

  // A slot whose last done arrives this cycle competes immediately, so an
  // uncontended response rises the cycle after that done.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    free_avail = 1'b0;
    free_idx   = '0;
    for (int s = 0; s < MAX_PENDING; s++) begin
      if (!win_valid && slots[s].valid && (slots[s].rsp_pend || done_now[s])) begin
        win_valid = 1'b1;
        win_idx   = SLOT_W'(s);
      end
      if (!free_avail && !slots[s].valid) begin
        free_avail = 1'b1;
        free_idx   = SLOT_W'(s);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < MAX_PENDING; s++) slots[s] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      for (int s = 0; s < MAX_PENDING; s++) begin
        if (slots[s].valid) begin
          slots[s].remaining <= rem_next[s];
          if (win_valid && (win_idx == SLOT_W'(s))) begin
            slots[s].valid    <= 1'b0;
            slots[s].rsp_pend <= 1'b0;
          end else if (done_now[s]) begin
            slots[s].rsp_pend <= 1'b1;
          end
        end
      end
      if (alloc_en) begin
        slots[free_idx].valid     <= 1'b1;
        slots[free_idx].id        <= alloc_id;
        slots[free_idx].remaining <= alloc_cnt;
        slots[free_idx].rsp_pend  <= 1'b0;
      end
      rsp_valid <= win_valid;
      rsp_id    <= win_valid ? slots[win_idx].id : '0;
    end
  end

endmodule

// File: rtl/vx_dispatch_launcher.sv
// Cluster-level dispatch consumer: accepts one block request, launches it onto consecutive
// cores (wrapping), tracks per-core ownership and reports block completion.
module vx_dispatch_launcher
  import vx_dispatch_pkg::*;
#(
  parameter int NUM_CORES   = VX_NUM_CORES,
  parameter int NC_WIDTH    = $clog2(NUM_CORES),
  parameter int NB_WIDTH    = VX_NB_WIDTH,
  parameter int MAX_PENDING = VX_MAX_PENDING
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [NB_WIDTH-1:0]  req_id,
  input  logic [NC_WIDTH-1:0]  req_size_m1,
  input  logic [NC_WIDTH-1:0]  req_core_id,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [NB_WIDTH-1:0]  rsp_id,
  output logic [NUM_CORES-1:0] core_launch_valid,
  output logic [NB_WIDTH-1:0]  core_launch_id,
  input  logic [NUM_CORES-1:0] core_launch_ready,
  input  logic [NUM_CORES-1:0] core_done
);

  launch_state_e               state;
  logic                        running;
  logic [NC_WIDTH-1:0]         cur_core;
  logic [NC_WIDTH:0]           to_launch;
  logic [NB_WIDTH-1:0]         cur_id;
  logic [SLOT_W-1:0]           cur_slot;
  logic [NUM_CORES-1:0]        busy;
  logic [SLOT_W-1:0]           owner [NUM_CORES];
  logic [NUM_CORES*SLOT_W-1:0] owner_flat;
  logic                        free_avail;
  logic [SLOT_W-1:0]           free_idx;
  logic                        accept;
  logic                        fire;
  logic [NUM_CORES-1:0]        fire_mask;
  logic [NUM_CORES-1:0]        done_mask;

  // running keeps req_ready low while reset is held.
  assign req_ready         = running && (state == IDLE) && free_avail;
  assign accept            = req_valid && req_ready;
  assign fire              = (state == LAUNCH) && !busy[cur_core] && core_launch_ready[cur_core];
  assign fire_mask         = fire ? (NUM_CORES'(1) << cur_core) : '0;
  assign core_launch_valid = fire_mask;
  assign core_launch_id    = fire ? cur_id : '0;
  assign done_mask         = core_done & busy;

  always_comb begin
    owner_flat = '0;
    for (int c = 0; c < NUM_CORES; c++) owner_flat[c*SLOT_W +: SLOT_W] = owner[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      cur_core  <= '0;
      to_launch <= '0;
      cur_id    <= '0;
      cur_slot  <= '0;
    end else begin
      running <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_core  <= req_core_id;
            to_launch <= (NC_WIDTH+1)'(req_size_m1) + (NC_WIDTH+1)'(1);
            cur_id    <= req_id;
            cur_slot  <= free_idx;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (fire) begin
            cur_core  <= cur_core + NC_WIDTH'(1);
            to_launch <= to_launch - (NC_WIDTH+1)'(1);
            if (to_launch == (NC_WIDTH+1)'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A launch never targets a busy core, so done and launch never collide on one bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int c = 0; c < NUM_CORES; c++) owner[c] <= '0;
    end else begin
      busy <= (busy & ~done_mask) | fire_mask;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (fire_mask[c]) owner[c] <= cur_slot;
      end
    end
  end

  vx_dispatch_slot_table #(
    .NUM_CORES  (NUM_CORES),
    .NC_WIDTH   (NC_WIDTH),
    .NB_WIDTH   (NB_WIDTH),
    .MAX_PENDING(MAX_PENDING)
  ) u_slot_table (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (accept),
    .alloc_id  (req_id),
    .alloc_cnt ((NC_WIDTH+1)'(req_size_m1) + (NC_WIDTH+1)'(1)),
    .free_avail(free_avail),
    .free_idx  (free_idx),
    .done_mask (done_mask),
    .owner_flat(owner_flat),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id)
  );

endmodule
